// File: rtl/audio_pkg.sv
// Shared types for the tone sequencer.
//   note_t      : one note-table entry {freq in Hz (0 = rest), duration in ticks}
//   seq_state_t : playback FSM states
//   tick_count  : clock cycles per duration tick, evaluated at elaboration
package audio_pkg;

  localparam int unsigned NOTE_DUR_W = 16;

  typedef struct packed {
    logic [31:0]           freq;
    logic [NOTE_DUR_W-1:0] dur;
  } note_t;

  typedef enum logic {
    SEQ_IDLE,
    SEQ_PLAY
  } seq_state_t;

  // Never returns 0 so the tick divider always has at least one cycle per tick.
  function automatic int unsigned tick_count(int unsigned clock_freq, int unsigned tick_hz);
    int unsigned t;
    t = clock_freq / tick_hz;
    return (t == 0) ? 1 : t;
  endfunction

endpackage

// File: rtl/seq_tick_gen.sv
// Divide-by-T tick generator.
//   clock : system clock
//   reset : synchronous active-high reset
//   clear : synchronous restart of the count (tick phase realigns to this edge)
//   tick  : high on the last cycle of every T-cycle period
module seq_tick_gen #(
  parameter int unsigned T = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (T > 1) ? $clog2(T) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == CW'(T - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CW'(T - 1));

endmodule

// File: rtl/tone_sequencer.sv
// Note-sequence player feeding the frequency input of a square-wave generator.
// Optional feature macro: SEQ_LOOP_EN (adds 'loop' input for continuous replay).
//   clock, reset        : system clock, synchronous active-high reset
//   wr_en/addr/freq/dur : note-table write port (always accepted)
//   seq_len             : notes to play, sampled at start, clamped to DEPTH
//   start, stop         : begin playback from entry 0 / abort playback
//   loop                : (SEQ_LOOP_EN only) wrap to entry 0 after the last note
//   out_freq, gate      : current tone (0 when silent) and tone-sounding flag
//   busy, note_idx      : playing flag and current entry index
//   done                : one-cycle pulse on natural completion
module tone_sequencer
  import audio_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned TICK_HZ    = 1000,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DUR_W      = 16,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [31:0]       wr_freq,
  input  logic [DUR_W-1:0]  wr_dur,
  input  logic [AW:0]       seq_len,
  input  logic              start,
  input  logic              stop,
`ifdef SEQ_LOOP_EN
  input  logic              loop,
`endif
  output logic [31:0]       out_freq,
  output logic              gate,
  output logic              busy,
  output logic [AW-1:0]     note_idx,
  output logic              done
);

  localparam int unsigned T_CYC = tick_count(CLOCK_FREQ, TICK_HZ);

  note_t            note_mem [DEPTH];
  seq_state_t       state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d, load_idx;
  logic [31:0]      freq_q, freq_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic [AW:0]      len_q, len_d, len_clamped;
  logic             done_d, load, tick, expire, last_note;
  logic             loop_q;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      note_mem[wr_addr] <= '{freq: wr_freq, dur: NOTE_DUR_W'(wr_dur)};
    end
  end

  seq_tick_gen #(.T(T_CYC)) u_tick (
    .clock (clock),
    .reset (reset),
    .clear (load),
    .tick  (tick)
  );

`ifdef SEQ_LOOP_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      loop_q <= 1'b0;
    end else if (state_q == SEQ_IDLE && start && !stop) begin
      loop_q <= loop;
    end
  end
`else
  assign loop_q = 1'b0;
`endif

  assign len_clamped = (seq_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : seq_len;
  // rem_q is 0 only for a zero-duration note, which expires after one cycle.
  assign expire      = (rem_q == '0) || (tick && rem_q == DUR_W'(1));
  assign last_note   = ({1'b0, idx_q} == len_q - (AW+1)'(1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    freq_d   = freq_q;
    rem_d    = rem_q;
    len_d    = len_q;
    done_d   = 1'b0;
    load     = 1'b0;
    load_idx = '0;
    unique case (state_q)
      SEQ_IDLE: begin
        if (start && !stop) begin
          if (len_clamped == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = SEQ_PLAY;
            len_d   = len_clamped;
            load    = 1'b1;
          end
        end
      end
      SEQ_PLAY: begin
        if (stop) begin
          state_d = SEQ_IDLE;
          idx_d   = '0;
          freq_d  = '0;
        end else if (expire) begin
          if (!last_note) begin
            load     = 1'b1;
            load_idx = idx_q + AW'(1);
          end else if (loop_q) begin
            load = 1'b1;
          end else begin
            state_d = SEQ_IDLE;
            idx_d   = '0;
            freq_d  = '0;
            done_d  = 1'b1;
          end
        end else if (tick) begin
          rem_d = rem_q - DUR_W'(1);
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
    // Reads the registered table, so a same-cycle write is seen only by later loads.
    if (load) begin
      idx_d  = load_idx;
      freq_d = note_mem[load_idx].freq;
      rem_d  = DUR_W'(note_mem[load_idx].dur);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SEQ_IDLE;
      idx_q   <= '0;
      freq_q  <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      freq_q  <= freq_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      done    <= done_d;
    end
  end

  assign out_freq = freq_q;
  assign gate     = (freq_q != '0);
  assign busy     = (state_q == SEQ_PLAY);
  assign note_idx = idx_q;

endmodule

// File: tb/tb_tone_sequencer.sv
module tb_tone_sequencer;

  localparam int unsigned T = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [31:0] wr_freq = '0;
  logic [15:0] wr_dur = '0;
  logic [2:0]  seq_len = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
`ifdef SEQ_LOOP_EN
  logic        loop = 1'b0;
`endif
  logic [31:0] out_freq;
  logic        gate, busy, done;
  logic [1:0]  note_idx;

  int unsigned checks = 0;
  int unsigned passed = 0;

  // packed expectation: {busy, gate, done, note_idx, out_freq}
  logic [36:0] exp_q [$];

  tone_sequencer #(
    .CLOCK_FREQ(1000),
    .TICK_HZ   (100),
    .DEPTH     (4),
    .DUR_W     (16)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_freq  (wr_freq),
    .wr_dur   (wr_dur),
    .seq_len  (seq_len),
    .start    (start),
    .stop     (stop),
`ifdef SEQ_LOOP_EN
    .loop     (loop),
`endif
    .out_freq (out_freq),
    .gate     (gate),
    .busy     (busy),
    .note_idx (note_idx),
    .done     (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [36:0] got, input logic [36:0] expv);
    checks++;
    if (got === expv) passed++;
    else $display("FAIL %s: got busy/gate/done/idx/freq=%h required=%h at %0t", tag, got, expv, $time);
  endtask

  function automatic logic [36:0] pack(input bit b, input bit d, input int unsigned idx, input int unsigned f);
    return {b, (b && f != 0), d, 2'(idx), 32'(f)};
  endfunction

  task automatic push_n(input int unsigned n, input bit b, input bit d, input int unsigned idx, input int unsigned f);
    for (int unsigned k = 0; k < n; k++) exp_q.push_back(pack(b, d, idx, f));
  endtask

  task automatic push_note(input int unsigned idx, input int unsigned f, input int unsigned dur);
    push_n((dur == 0) ? 1 : dur * T, 1'b1, 1'b0, idx, f);
  endtask

  task automatic push_done();
    push_n(1, 1'b0, 1'b1, 0, 0);
    push_n(2, 1'b0, 1'b0, 0, 0);
  endtask

  // Advances one clock per queued expectation; one-cycle pulses are dropped after each edge.
  task automatic drain(input string tag);
    while (exp_q.size() != 0) begin
      @(posedge clock);
      #1;
      start = 1'b0;
      stop  = 1'b0;
      wr_en = 1'b0;
      check(tag, {busy, gate, done, note_idx, out_freq}, exp_q.pop_front());
    end
  endtask

  task automatic write_note(input int unsigned a, input int unsigned f, input int unsigned d);
    wr_en   = 1'b1;
    wr_addr = 2'(a);
    wr_freq = 32'(f);
    wr_dur  = 16'(d);
    @(posedge clock);
    #1;
    wr_en = 1'b0;
  endtask

  initial begin
    // reset values
    repeat (2) @(posedge clock);
    #1;
    push_n(2, 1'b0, 1'b0, 0, 0);
    drain("reset");
    reset = 1'b0;

    // basic three-note sequence with a rest
    write_note(0, 440, 3);
    write_note(1, 0, 2);
    write_note(2, 880, 1);
    seq_len = 3'd3;
    start   = 1'b1;
    push_note(0, 440, 3);
    push_note(1, 0, 2);
    push_note(2, 880, 1);
    push_done();
    drain("seq3");

    // zero-duration note lasts one cycle
    write_note(0, 500, 0);
    write_note(1, 600, 2);
    seq_len = 3'd2;
    start   = 1'b1;
    push_note(0, 500, 0);
    push_note(1, 600, 2);
    push_done();
    drain("dur0");

    // stop mid-note, no done afterwards
    write_note(0, 440, 5);
    seq_len = 3'd1;
    start   = 1'b1;
    push_n(12, 1'b1, 1'b0, 0, 440);
    drain("stop_pre");
    stop = 1'b1;
    push_n(50, 1'b0, 1'b0, 0, 0);
    drain("stop_post");

    // empty sequence pulses done only
    seq_len = 3'd0;
    start   = 1'b1;
    push_done();
    drain("len0");

    // start together with stop is ignored
    seq_len = 3'd1;
    start   = 1'b1;
    stop    = 1'b1;
    push_n(3, 1'b0, 1'b0, 0, 0);
    drain("start_stop");

    // write to the playing entry only affects the next playback
    write_note(0, 440, 3);
    seq_len = 3'd1;
    start   = 1'b1;
    push_n(5, 1'b1, 1'b0, 0, 440);
    drain("wr_live_pre");
    wr_en   = 1'b1;
    wr_addr = 2'd0;
    wr_freq = 32'd1000;
    wr_dur  = 16'd3;
    push_n(25, 1'b1, 1'b0, 0, 440);
    push_done();
    drain("wr_live_post");
    start = 1'b1;
    push_note(0, 1000, 3);
    push_done();
    drain("wr_replay");

    // seq_len above DEPTH clamps; start while busy ignored
    write_note(0, 100, 1);
    write_note(1, 200, 0);
    write_note(2, 300, 1);
    write_note(3, 400, 0);
    seq_len = 3'd7;
    start   = 1'b1;
    push_n(5, 1'b1, 1'b0, 0, 100);
    drain("clamp_pre");
    start = 1'b1;
    push_n(5, 1'b1, 1'b0, 0, 100);
    push_note(1, 200, 0);
    push_note(2, 300, 1);
    push_note(3, 400, 0);
    push_done();
    drain("clamp");

    // reset during playback
    seq_len = 3'd2;
    start   = 1'b1;
    push_n(4, 1'b1, 1'b0, 0, 100);
    drain("rst_pre");
    reset = 1'b1;
    push_n(2, 1'b0, 1'b0, 0, 0);
    drain("rst_mid");
    reset = 1'b0;

`ifdef SEQ_LOOP_EN
    // continuous replay until stop
    write_note(0, 100, 1);
    write_note(1, 200, 1);
    seq_len = 3'd2;
    loop    = 1'b1;
    start   = 1'b1;
    for (int r = 0; r < 2; r++) begin
      push_note(0, 100, 1);
      push_note(1, 200, 1);
    end
    push_n(5, 1'b1, 1'b0, 0, 100);
    drain("loop");
    loop = 1'b0;
    stop = 1'b1;
    push_n(25, 1'b0, 1'b0, 0, 0);
    drain("loop_stop");
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
